// File: rtl/ex_stage.sv
// Execute stage: registers the decode bus, evaluates the one-hot ALU, issues the data-SRAM request, and runs a 32-step divider.
// Latency: ALU, SRAM request and forwarding take one stage cycle; DIV/DIVU take 34 cycles, or 2 cycles when the divisor is 0.
// Backpressure: stallreq_for_ex freezes the upstream stages while a divide is in flight; stall[3] holds the input register.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 141
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_id,
  output logic                    ex_is_load,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [ID_TO_EX_WD-1:0] r_bus;
  logic [1:0]  r_state;
  logic [5:0]  r_count;
  logic [31:0] r_quo;   // dividend shifts out of the top, quotient bits shift in at the bottom
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_done;  // this divide has already produced its result; blocks a re-issue while held

  // Decode-bus fields
  logic [31:0] w_pc, w_inst, w_rs, w_rt;
  logic [11:0] w_alu_op;
  logic [2:0]  w_sel1;
  logic [3:0]  w_sel2;
  logic        w_ram_en, w_rf_we, w_sel_res;
  logic [3:0]  w_ram_wen;
  logic [4:0]  w_waddr;

  assign w_pc      = r_bus[158:127];
  assign w_inst    = r_bus[126:95];
  assign w_alu_op  = r_bus[94:83];
  assign w_sel1    = r_bus[82:80];
  assign w_sel2    = r_bus[79:76];
  assign w_ram_en  = r_bus[75];
  assign w_ram_wen = r_bus[74:71];
  assign w_rf_we   = r_bus[70];
  assign w_waddr   = r_bus[69:65];
  assign w_sel_res = r_bus[64];
  assign w_rs      = r_bus[63:32];
  assign w_rt      = r_bus[31:0];

  // Operand selection: one-hot masks ORed together, nothing selected yields 0
  logic [31:0] w_src1, w_src2;
  assign w_src1 = ({32{w_sel1[0]}} & w_rs)
                | ({32{w_sel1[1]}} & w_pc)
                | ({32{w_sel1[2]}} & {27'b0, w_inst[10:6]});
  assign w_src2 = ({32{w_sel2[0]}} & w_rt)
                | ({32{w_sel2[1]}} & {{16{w_inst[15]}}, w_inst[15:0]})
                | ({32{w_sel2[2]}} & 32'd8)
                | ({32{w_sel2[3]}} & {16'b0, w_inst[15:0]});

  logic [31:0] w_add, w_sub, w_slt, w_sltu, w_and, w_nor, w_or, w_xor;
  logic [31:0] w_sll, w_srl, w_sra, w_lui, w_ex_result;
  logic [4:0]  w_sa;
  assign w_sa   = w_src1[4:0];
  assign w_add  = w_src1 + w_src2;
  assign w_sub  = w_src1 - w_src2;
  assign w_slt  = {31'b0, $signed(w_src1) < $signed(w_src2)};
  assign w_sltu = {31'b0, w_src1 < w_src2};
  assign w_and  = w_src1 & w_src2;
  assign w_nor  = ~(w_src1 | w_src2);
  assign w_or   = w_src1 | w_src2;
  assign w_xor  = w_src1 ^ w_src2;
  assign w_sll  = w_src2 << w_sa;
  assign w_srl  = w_src2 >> w_sa;
  assign w_sra  = $signed(w_src2) >>> w_sa;
  assign w_lui  = {w_src2[15:0], 16'b0};

  assign w_ex_result = ({32{w_alu_op[11]}} & w_add)
                     | ({32{w_alu_op[10]}} & w_sub)
                     | ({32{w_alu_op[9]}}  & w_slt)
                     | ({32{w_alu_op[8]}}  & w_sltu)
                     | ({32{w_alu_op[7]}}  & w_and)
                     | ({32{w_alu_op[6]}}  & w_nor)
                     | ({32{w_alu_op[5]}}  & w_or)
                     | ({32{w_alu_op[4]}}  & w_xor)
                     | ({32{w_alu_op[3]}}  & w_sll)
                     | ({32{w_alu_op[2]}}  & w_srl)
                     | ({32{w_alu_op[1]}}  & w_sra)
                     | ({32{w_alu_op[0]}}  & w_lui);

  // Divide detection and operand magnitudes
  logic        w_is_div, w_is_divu, w_div_any, w_start;
  logic [31:0] w_rs_mag, w_rt_mag;
  assign w_is_div  = (w_inst[31:26] == 6'b0) && (w_inst[5:0] == 6'b011010);
  assign w_is_divu = (w_inst[31:26] == 6'b0) && (w_inst[5:0] == 6'b011011);
  assign w_div_any = w_is_div | w_is_divu;
  assign w_start   = w_div_any & ~r_done;
  assign w_rs_mag  = (w_is_div && w_rs[31]) ? (~w_rs + 32'd1) : w_rs;
  assign w_rt_mag  = (w_is_div && w_rt[31]) ? (~w_rt + 32'd1) : w_rt;

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic        w_fits;
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = {1'b0, w_shift} - {2'b0, r_dvs};
  assign w_fits  = ~w_diff[33];

  // Input register: bubble when decode stops but execute advances, hold when execute stops
  always_ff @(posedge clk) begin
    if (rst)                      r_bus <= '0;
    else if (stall[2] && !stall[3]) r_bus <= '0;
    else if (!stall[3])           r_bus <= id_to_ex_bus;
  end

  // Divider sequencer: IDLE -> RUN x32 -> DONE, or IDLE -> DONE for a zero divisor
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= 6'd0;
      r_quo   <= 32'd0;
      r_rem   <= 32'd0;
      r_dvs   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (w_rt == 32'd0) begin
              r_state <= S_DONE;
              r_quo   <= 32'hFFFF_FFFF;
              r_rem   <= w_rs;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_quo   <= w_rs_mag;
              r_rem   <= 32'd0;
              r_dvs   <= w_rt_mag;
              r_count <= 6'd0;
              r_neg_q <= w_is_div & (w_rs[31] ^ w_rt[31]);
              r_neg_r <= w_is_div & w_rs[31];
            end
          end
        end
        S_RUN: begin
          r_rem   <= w_fits ? w_diff[31:0] : w_shift[31:0];
          r_quo   <= {r_quo[30:0], w_fits};
          r_count <= r_count + 6'd1;
          if (r_count == 6'd31) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky completion: set when the result is shown but the stage is held, cleared when the register loads
  always_ff @(posedge clk) begin
    if (rst)                     r_done <= 1'b0;
    else if (!stall[3])          r_done <= 1'b0;
    else if (r_state == S_DONE)  r_done <= 1'b1;
  end

  logic        w_hilo_we;
  logic [31:0] w_hi, w_lo;
  assign w_hilo_we = (r_state == S_DONE);
  assign w_lo = !w_hilo_we ? 32'd0 : (r_neg_q ? (~r_quo + 32'd1) : r_quo);
  assign w_hi = !w_hilo_we ? 32'd0 : (r_neg_r ? (~r_rem + 32'd1) : r_rem);

  assign stallreq_for_ex = w_start & (r_state != S_DONE);

  assign ex_to_mem_bus   = {w_pc, w_ram_en, w_ram_wen, w_sel_res, w_rf_we, w_waddr,
                            w_ex_result, w_hilo_we, w_hi, w_lo};
  assign ex_to_id        = {w_rf_we, w_waddr, w_ex_result};
  assign ex_is_load      = w_ram_en & ~|w_ram_wen;
  assign data_sram_en    = w_ram_en;
  assign data_sram_wen   = w_ram_wen;
  assign data_sram_addr  = w_ex_result;
  assign data_sram_wdata = w_rt;

  logic w_unused;
  assign w_unused = ^{w_inst[25:16], stall[5:4], stall[1:0], w_diff[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed ALU table, randomized ALU/divide traffic against a reference model,
// and hand-written sequences for divide timing, held DONE, reset abort and back-to-back divides.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   tb_stall;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [140:0] ex_to_mem_bus;
  logic [37:0]  ex_to_id;
  logic         ex_is_load;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;

  always #5 clk = ~clk;

  // Pipeline controller: an execute stall request freezes stages 0..3
  assign stall = tb_stall | (stallreq_for_ex ? 6'b001111 : 6'b000000);

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
    .ex_to_mem_bus(ex_to_mem_bus), .ex_to_id(ex_to_id), .ex_is_load(ex_is_load),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .stallreq_for_ex(stallreq_for_ex)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [158:0] mk_bus(
      input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
      input logic [2:0] s1, input logic [3:0] s2, input logic ram_en, input logic [3:0] wen,
      input logic rf_we, input logic [4:0] waddr, input logic sel_res,
      input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, ram_en, wen, rf_we, waddr, sel_res, rs, rt};
  endfunction

  // Reference ALU. Operation index: 11 add .. 0 lui, 12 none.
  // src1 index: 0 rs, 1 pc, 2 shamt, 3 none. src2 index: 0 rt, 1 sext imm, 2 eight, 3 zext imm, 4 none.
  function automatic logic [31:0] ref_alu(input int op_idx, input int s1_idx, input int s2_idx,
      input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt);
    logic [31:0] a, b, r;
    int sh;
    case (s1_idx)
      0: a = rs;
      1: a = pc;
      2: a = 32'(inst[10:6]);
      default: a = 32'd0;
    endcase
    case (s2_idx)
      0: b = rt;
      1: b = 32'(int'($signed(inst[15:0])));
      2: b = 32'd8;
      3: b = 32'(inst[15:0]);
      default: b = 32'd0;
    endcase
    sh = int'(a % 32);
    case (op_idx)
      11: r = a + b;
      10: r = a - b;
      9:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      8:  r = (a < b) ? 32'd1 : 32'd0;
      7:  r = a & b;
      6:  r = ~(a | b);
      5:  r = a | b;
      4:  r = a ^ b;
      3:  r = b << sh;
      2:  r = b >> sh;
      1:  r = b[31] ? ~((~b) >> sh) : (b >> sh);
      0:  r = b * 32'd65536;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic ref_div(input logic sgn, input logic [31:0] rs, input logic [31:0] rt,
                         output logic [31:0] q, output logic [31:0] r);
    longint a, b;
    if (rt == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = rs;
    end else begin
      if (sgn) begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
      end else begin
        a = longint'({32'b0, rs});
        b = longint'({32'b0, rt});
      end
      q = 32'(a / b);
      r = 32'(a % b);
    end
  endtask

  // Issue one divide, scramble the bus while it runs, and check occupancy and results in DONE
  task automatic run_div(input logic sgn, input logic [31:0] rs, input logic [31:0] rt, input string tag);
    logic [31:0]  q, r, inst;
    logic [159:0] g;
    int n, exp_stall;
    ref_div(sgn, rs, rt, q, r);
    exp_stall = (rt == 32'd0) ? 1 : 33;
    inst = sgn ? 32'h0085_001A : 32'h0085_001B;
    id_to_ex_bus = mk_bus(32'h0040_0100, inst, 12'h0, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 1'b0, rs, rt);
    @(posedge clk); #1;
    g = {$urandom, $urandom, $urandom, $urandom, $urandom};
    id_to_ex_bus = g[158:0];
    n = 0;
    while (stallreq_for_ex && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk({tag, "_stall_cycles"}, 160'(n), 160'(exp_stall));
    chk({tag, "_hilo_we"}, 160'(ex_to_mem_bus[64]), 160'(1'b1));
    chk({tag, "_lo"}, 160'(ex_to_mem_bus[31:0]), 160'(q));
    chk({tag, "_hi"}, 160'(ex_to_mem_bus[63:32]), 160'(r));
    chk({tag, "_to_id"}, 160'(ex_to_id), 160'(38'd0));
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic        ram_en;
    logic [3:0]  wen;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  int op_idx, s1_idx, s2_idx;
  logic [31:0] r_pc, r_inst, r_rs, r_rt, r_exp;
  logic        r_ram_en, r_rf_we, r_sel;
  logic [3:0]  r_wen;
  logic [4:0]  r_waddr;
  logic [11:0] r_op;
  logic [2:0]  r_s1;
  logic [3:0]  r_s2;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            pc             inst           op      s1      s2       en    wen    rs             rt             expected
    tbl[0]  = '{32'h0040_0000, 32'h2485_FFFF, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 32'd5,         32'h0000_1111, 32'd4};
    tbl[1]  = '{32'h0040_0004, 32'h34A5_1234, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0, 32'h0F0F_0000, 32'd0,         32'h0F0F_1234};
    tbl[2]  = '{32'h0040_0008, 32'h3C05_1234, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0, 32'hDEAD_0000, 32'd0,         32'h1234_0000};
    tbl[3]  = '{32'h0040_000C, 32'h0085_282A, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'd1,         32'd1};
    tbl[4]  = '{32'h0040_0010, 32'h0085_282B, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'd1,         32'd0};
    tbl[5]  = '{32'h0040_0014, 32'h0085_2823, 12'h400, 3'b001, 4'b0001, 1'b0, 4'h0, 32'd3,         32'd5,         32'hFFFF_FFFE};
    tbl[6]  = '{32'h0040_0018, 32'h0000_0100, 12'h008, 3'b100, 4'b0001, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0010};
    tbl[7]  = '{32'h0040_001C, 32'h0000_0102, 12'h004, 3'b100, 4'b0001, 1'b0, 4'h0, 32'd0,         32'h8000_0000, 32'h0800_0000};
    tbl[8]  = '{32'h0040_0020, 32'h0000_0103, 12'h002, 3'b100, 4'b0001, 1'b0, 4'h0, 32'd0,         32'h8000_0000, 32'hF800_0000};
    tbl[9]  = '{32'h0040_0024, 32'h0085_2827, 12'h040, 3'b001, 4'b0001, 1'b0, 4'h0, 32'd0,         32'h0000_00FF, 32'hFFFF_FF00};
    tbl[10] = '{32'h0000_1000, 32'h0C00_0400, 12'h800, 3'b010, 4'b0100, 1'b0, 4'h0, 32'd0,         32'd0,         32'h0000_1008};
    tbl[11] = '{32'h0040_0028, 32'h0085_2824, 12'h080, 3'b001, 4'b0001, 1'b0, 4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    tbl[12] = '{32'h0040_002C, 32'h0085_2826, 12'h010, 3'b001, 4'b0001, 1'b0, 4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    tbl[13] = '{32'h0040_0030, 32'hAC85_0010, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_BABE, 32'h0000_0110};
    tbl[14] = '{32'h0040_0034, 32'h8C85_FFFC, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 32'h0000_0200, 32'h1234_5678, 32'h0000_01FC};
    tbl[15] = '{32'h0,         32'h0,         12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 32'd0,         32'd0,         32'd0};

    // Reset for two cycles with a zero bus
    rst = 1'b1;
    tb_stall = 6'b0;
    id_to_ex_bus = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mem_bus", 160'(ex_to_mem_bus), 160'd0);
    chk("rst_to_id", 160'(ex_to_id), 160'd0);
    chk("rst_sram", 160'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_is_load}), 160'd0);
    chk("rst_stallreq", 160'(stallreq_for_ex), 160'd0);

    // Directed ALU table
    for (int i = 0; i < 16; i++) begin
      r_rf_we = (i != 15);
      r_waddr = 5'(i + 1);
      if (i == 15) r_waddr = 5'd0;
      id_to_ex_bus = mk_bus(tbl[i].pc, tbl[i].inst, tbl[i].op, tbl[i].s1, tbl[i].s2,
                            tbl[i].ram_en, tbl[i].wen, r_rf_we, r_waddr, 1'b0, tbl[i].rs, tbl[i].rt);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_to_id", i), 160'(ex_to_id), 160'({r_rf_we, r_waddr, tbl[i].exp}));
      chk($sformatf("vec%0d_mem_bus", i), 160'(ex_to_mem_bus),
          160'({tbl[i].pc, tbl[i].ram_en, tbl[i].wen, 1'b0, r_rf_we, r_waddr, tbl[i].exp, 65'd0}));
      chk($sformatf("vec%0d_sram", i),
          160'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_is_load}),
          160'({tbl[i].ram_en, tbl[i].wen, tbl[i].exp, tbl[i].rt, tbl[i].ram_en & (tbl[i].wen == 4'h0)}));
    end

    // Decode stopped, execute running: a bubble enters
    id_to_ex_bus = mk_bus(tbl[0].pc, tbl[0].inst, tbl[0].op, tbl[0].s1, tbl[0].s2,
                          1'b0, 4'h0, 1'b1, 5'd9, 1'b0, tbl[0].rs, tbl[0].rt);
    @(posedge clk); #1;
    chk("pre_bubble_result", 160'(data_sram_addr), 160'(32'd4));
    tb_stall = 6'b000100;
    @(posedge clk); #1;
    chk("bubble_mem_bus", 160'(ex_to_mem_bus), 160'd0);
    tb_stall = 6'b0;

    // Randomized ALU traffic
    for (int k = 0; k < 150; k++) begin
      op_idx = $urandom_range(0, 12);
      s1_idx = $urandom_range(0, 3);
      s2_idx = $urandom_range(0, 4);
      r_op = (op_idx == 12) ? 12'h0 : (12'h1 << op_idx);
      r_s1 = (s1_idx == 3) ? 3'h0 : (3'h1 << s1_idx);
      r_s2 = (s2_idx == 4) ? 4'h0 : (4'h1 << s2_idx);
      r_pc = $urandom;
      r_inst = $urandom | 32'h8000_0000;
      r_rs = $urandom;
      r_rt = $urandom;
      r_ram_en = 1'($urandom_range(0, 1));
      r_wen = 4'($urandom_range(0, 15));
      r_rf_we = 1'($urandom_range(0, 1));
      r_waddr = 5'($urandom_range(0, 31));
      r_sel = 1'($urandom_range(0, 1));
      id_to_ex_bus = mk_bus(r_pc, r_inst, r_op, r_s1, r_s2, r_ram_en, r_wen, r_rf_we, r_waddr, r_sel, r_rs, r_rt);
      @(posedge clk); #1;
      r_exp = ref_alu(op_idx, s1_idx, s2_idx, r_pc, r_inst, r_rs, r_rt);
      chk("rnd_mem_bus", 160'(ex_to_mem_bus),
          160'({r_pc, r_ram_en, r_wen, r_sel, r_rf_we, r_waddr, r_exp, 65'd0}));
      chk("rnd_load_flag", 160'(ex_is_load), 160'(r_ram_en & (r_wen == 4'h0)));
    end

    // Signed divide with mixed signs
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");

    // Held in DONE: the divide must not restart
    id_to_ex_bus = '0;
    tb_stall = 6'b001000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("held_no_restart", 160'(stallreq_for_ex), 160'd0);
      chk("held_hilo_we", 160'(ex_to_mem_bus[64]), 160'd0);
    end
    tb_stall = 6'b0;
    @(posedge clk); #1;
    chk("after_hold_zero", 160'(ex_to_mem_bus), 160'd0);

    // Divide by zero, then back-to-back divides loaded at the end of DONE
    run_div(1'b0, 32'd7, 32'd0, "divu_7_0");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_div(1'b1, 32'd12345, 32'd0, "div_by_zero_s");
    for (int k = 0; k < 6; k++) begin
      r_rs = $urandom;
      r_rt = (k == 5) ? 32'd1 : ($urandom >> $urandom_range(0, 28));
      run_div(1'(k % 2), r_rs, r_rt, $sformatf("div_rnd%0d", k));
    end

    // Reset during RUN aborts the divide
    id_to_ex_bus = mk_bus(32'h0040_0200, 32'h0085_001A, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                          32'hFFFF_FF9C, 32'd3);
    @(posedge clk); #1;
    id_to_ex_bus = '0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("mid_run_stallreq", 160'(stallreq_for_ex), 160'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_stallreq", 160'(stallreq_for_ex), 160'd0);
    chk("abort_mem_bus", 160'(ex_to_mem_bus), 160'd0);
    rst = 1'b0;
    run_div(1'b0, 32'd100, 32'd7, "divu_100_7");

    id_to_ex_bus = '0;
    @(posedge clk); #1;
    chk("final_idle", 160'({stallreq_for_ex, ex_to_mem_bus}), 160'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
